// File: rtl/fm_feeder.sv
// Streams 64-bit feature words from BRAM_FM64 into an 8-lane systolic array with diagonal skew,
// one row-tile at a time, handshaking with CTRL between tiles.
module fm_feeder #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           M,
    input  logic [15:0]           N,
    input  logic                  feed_start,
    output logic                  feed_finish,
    output logic                  tile_done,
    input  logic                  tile_ack,
    output logic [15:0]           tile_idx,
    output logic [AW-1:0]         BRAM_FM64_raddr,
    input  logic [63:0]           BRAM_FM64_rddata,
    output logic [LANES*DW-1:0]   fm_data,
    output logic [LANES-1:0]      fm_valid
);

    localparam int unsigned CW = $clog2(LANES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCom,
        StRead,
        StDrain,
        StWaitAck,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     w_q, w_d;
    logic [15:0]     ncols_q, ncols_d;
    logic [15:0]     m_q, m_d;
    logic [15:0]     k_q, k_d;
    logic [15:0]     n_q, n_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            finish_q, finish_d;
    logic            rd_vld_q;
    logic [LANES-1:0] lane_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            w_q      <= '0;
            ncols_q  <= '0;
            m_q      <= '0;
            k_q      <= '0;
            n_q      <= '0;
            raddr_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            ncols_q  <= ncols_d;
            m_q      <= m_d;
            k_q      <= k_d;
            n_q      <= n_d;
            raddr_q  <= raddr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            finish_q <= finish_d;
            // Every READ cycle issues one address; its data returns the next cycle.
            rd_vld_q <= (state_q == StRead);
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        ncols_d  = ncols_q;
        m_d      = m_q;
        k_d      = k_q;
        n_d      = n_q;
        raddr_d  = raddr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        finish_d = finish_q;
        if (feed_start) finish_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (feed_start) state_d = StCom;
            end
            StCom: begin
                w_d     = ((M - 16'd1) >> 3) + 16'd1;
                ncols_d = N;
                m_d     = M;
                k_d     = '0;
                n_d     = '0;
                raddr_d = '0;
                cnt_d   = '0;
                state_d = (M == 16'd0 || N == 16'd0) ? StFinish : StRead;
            end
            StRead: begin
                if (n_q == ncols_q - 16'd1) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    n_d     = n_q + 16'd1;
                    raddr_d = raddr_q + AW'(w_q);
                end
            end
            StDrain: begin
                // Last address plus LANES+1 cycles: lane 7 of the last column is on the outputs.
                if (cnt_q == CW'(LANES - 1)) begin
                    state_d = StWaitAck;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitAck: begin
                if (tile_ack) begin
                    if (k_q == w_q - 16'd1) begin
                        state_d = StFinish;
                    end else begin
                        k_d     = k_q + 16'd1;
                        n_d     = '0;
                        raddr_d = AW'(k_q + 16'd1);
                        state_d = StRead;
                    end
                end
            end
            StFinish: begin
                finish_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Lane i carries feature row 8k+i; rows past M are masked on the partial last tile.
    always_comb begin
        lane_on = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_on[i] = ({1'b0, k_q, 3'b000} + 20'(i)) < {4'b0000, m_q};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] d_q [0:i];
        logic [i:0]    v_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) d_q[j] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= (rd_vld_q && lane_on[i]) ? BRAM_FM64_rddata[i*DW +: DW] : '0;
                v_q[0] <= rd_vld_q && lane_on[i];
                for (int j = 1; j <= i; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign fm_data[i*DW +: DW] = d_q[i];
        assign fm_valid[i]         = v_q[i];
    end

    assign feed_finish     = finish_q;
    assign tile_done       = done_q;
    assign tile_idx        = k_q;
    assign BRAM_FM64_raddr = raddr_q;

endmodule

// File: doc/fm_feeder.md
Name: fm_feeder

Overview:
- Downstream consumer of the 64-bit feature buffer BRAM_FM64.
- Each 64-bit word holds 8 int8 features m=8k..8k+7 of column n, at address n*W+k, where W=ceil(M/8).
- Per row-tile k, the block streams columns n=0..N-1 into an 8-lane systolic array with diagonal skew: lane i is delayed i cycles.
- After each tile it handshakes with CTRL before starting the next tile.

Parameters:
- LANES, 8, number of array rows and output lanes; fixed to 8 to match the 64-bit word.
- DW, 8, bits per feature lane.
- AW, 16, BRAM_FM64 address width.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- M  input  16  feature rows; sampled in COM.
- N  input  16  feature columns; sampled in COM.
- feed_start  input  1  start request; honoured only in IDLE.
- feed_finish  output  1  level; set on FINISH, cleared by feed_start.
- tile_done  output  1  one-cycle pulse when a tile is fully drained.
- tile_ack  input  1  CTRL allows the next tile; sampled only in WAIT_ACK.
- tile_idx  output  16  current tile k.
- BRAM_FM64_raddr  output  AW  registered read address.
- BRAM_FM64_rddata  input  64  read data, valid 1 cycle after raddr.
- fm_data  output  LANES*DW  skewed lanes; lane i is bits [8i+7:8i].
- fm_valid  output  LANES  per-lane valid.

Behaviour:
- Reset (rst=0, async): every output is 0 and the state is IDLE.
  - This applies mid-operation: skew pipes are flushed and no tile_done is emitted.
- Reset release: the first active edge loads state normally.
- FSM states: IDLE -> COM -> READ -> DRAIN -> WAIT_ACK -> (READ | FINISH) -> IDLE.
- IDLE:
  - feed_start=1 -> COM.
  - feed_start in any other state is ignored, except that it clears feed_finish.
- COM:
  - Latch W=((M-1)>>3)+1 and Ncols=N.
  - Set k=0, n=0, raddr=0.
  - If M==0 or N==0 -> FINISH directly: no reads, no tile_done.
  - Otherwise -> READ.
- READ:
  - One address per cycle: raddr = n*W + k, produced by an accumulator (raddr += W per column; no multiplier).
  - n counts 0..Ncols-1.
  - On n==Ncols-1 -> DRAIN.
- Read pipeline:
  - rd_vld follows each issued address by 1 cycle.
  - Lane 0 output register captures rddata[7:0] on the cycle after rddata is valid.
  - Lane i passes through i further registers.
  - Column n lane i appears on fm_data/fm_valid 2+i cycles after its address is first presented.
- Masking: if 8k+i >= M (last tile, partial), lane i outputs data 0 with fm_valid[i]=0; the skew timing is unchanged.
- DRAIN:
  - Counts LANES+1 cycles after the last address so lane 7 of the last column has been presented.
  - Then tile_done=1 for exactly 1 cycle -> WAIT_ACK.
- WAIT_ACK:
  - On tile_ack=1: if k==W-1 -> FINISH.
  - Otherwise k++, n=0, raddr=k+1 -> READ.
  - tile_ack outside WAIT_ACK has no effect.
- FINISH: feed_finish<=1 -> IDLE.
- fm_valid is 0 whenever the lane pipe holds no data.
- Widths:
  - raddr wraps modulo 2^AW; no overflow detection, since CTRL guarantees N*W <= 2^AW.
  - tile_idx equals k and holds its value after FINISH until the next COM.

Test Plan:
- M=8, N=3, BRAM word n = 0x0706050403020100 + n*0x0101010101010101 -> raddr 0,1,2 in consecutive cycles. Lane i shows byte i of word n, 2+i cycles after its address. One tile_done; after tile_ack, feed_finish=1.
- M=20, N=2 (W=3) -> raddr sequence 0,3 / 1,4 / 2,5 across tiles 0..2. In tile 2, fm_valid[7:4] are never asserted and those lanes stay 0. Exactly 3 tile_done pulses.
- tile_ack held low 5 cycles after tile_done -> no new raddr change and no fm_valid until ack. The next tile starts the cycle after ack is sampled.
- M=0 (or N=0) with feed_start -> feed_finish=1 within 3 cycles, no raddr activity, no tile_done.
- feed_start pulsed during READ -> ignored, sequence unchanged. A second feed_start after FINISH clears feed_finish the next cycle and reruns.
- rst=0 asserted mid-READ with M=16, N=4 -> all outputs 0 immediately (async). After release, state is IDLE and no tile_done is emitted.
